// File: rtl/syscall_input.sv
// syscall_input: services read_int (v0=5) and read_string (v0=8)
// syscalls from a byte-wide console stream while freezing the pipeline.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   syscall_control   decode stage flags a syscall instruction
//   v0, a0, a1        syscall code, string base address, buffer size
//   in_valid/in_ready console byte handshake, in_data is the byte
//   sysstall          pipeline freeze request (combinational)
//   rd_we, rd_data    one-cycle write of the read_int/read_char result to v0
//   mem_we, mem_addr, mem_wdata  byte write into data memory
//
// Optional feature: define SYSCALL_READ_CHAR_EN to add read_char (v0=12).
module syscall_input (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall_control,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        sysstall,
    output logic        rd_we,
    output logic [31:0] rd_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata
);

    localparam logic [31:0] CODE_INT = 32'd5;
    localparam logic [31:0] CODE_STR = 32'd8;
    localparam logic [7:0]  CH_NL    = 8'h0A;
    localparam logic [7:0]  CH_MINUS = 8'h2D;

`ifdef SYSCALL_READ_CHAR_EN
    localparam logic [31:0] CODE_CHR = 32'd12;

    typedef enum logic [2:0] {
        S_IDLE, S_INT, S_STR, S_TERM, S_WB, S_CHR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_INT, S_STR, S_TERM, S_WB
    } state_t;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] base;
    logic [31:0] size;
    logic [31:0] idx;
    logic [31:0] acc;
    logic        neg;
    logic        first;

    logic        is_int;
    logic        is_str;
    logic        is_chr;
    logic        start;
    logic        load;
    logic        accept;
    logic        is_digit;
    logic [31:0] digit;

    assign is_int = (v0 == CODE_INT);
    assign is_str = (v0 == CODE_STR);
`ifdef SYSCALL_READ_CHAR_EN
    assign is_chr = (v0 == CODE_CHR);
`else
    assign is_chr = 1'b0;
`endif
    assign start = syscall_control && (is_int || is_str || is_chr);

    assign accept   = in_valid && in_ready;
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign digit    = {24'd0, in_data - 8'h30};
    assign load     = (state == S_IDLE) && (state_next != S_IDLE);

    // The reset gate keeps the freeze request low while reset is held,
    // even if the decode stage is presenting a syscall.
    assign sysstall = !reset && ((state != S_IDLE) || start);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rd_we      = 1'b0;
        rd_data    = 32'd0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 8'd0;
        unique case (state)
            S_IDLE: begin
                if (syscall_control) begin
                    if (is_int)
                        state_next = S_INT;
                    else if (is_str)
                        state_next = S_STR;
`ifdef SYSCALL_READ_CHAR_EN
                    else if (is_chr)
                        state_next = S_CHR;
`endif
                end
            end
            S_INT: begin
                in_ready = 1'b1;
                if (in_valid && in_data == CH_NL)
                    state_next = S_WB;
            end
            S_STR: begin
                // Slot n-1 is reserved for the NUL terminator, so a
                // one-byte buffer goes to TERM without taking input.
                if (size == 32'd0) begin
                    state_next = S_IDLE;
                end else if (idx == size - 32'd1) begin
                    state_next = S_TERM;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        mem_we    = 1'b1;
                        mem_addr  = base + idx;
                        mem_wdata = in_data;
                        if (in_data == CH_NL ||
                            idx + 32'd1 == size - 32'd1)
                            state_next = S_TERM;
                    end
                end
            end
            S_TERM: begin
                mem_we     = 1'b1;
                mem_addr   = base + idx;
                state_next = S_IDLE;
            end
            S_WB: begin
                rd_we      = 1'b1;
                rd_data    = neg ? -acc : acc;
                state_next = S_IDLE;
            end
`ifdef SYSCALL_READ_CHAR_EN
            S_CHR: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = S_WB;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            base  <= 32'd0;
            size  <= 32'd0;
            idx   <= 32'd0;
            acc   <= 32'd0;
            neg   <= 1'b0;
            first <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                base  <= a0;
                size  <= a1;
                idx   <= 32'd0;
                acc   <= 32'd0;
                neg   <= 1'b0;
                first <= 1'b1;
            end
            if (accept) begin
                if (state == S_INT) begin
                    first <= 1'b0;
                    if (first && in_data == CH_MINUS)
                        neg <= 1'b1;
                    else if (is_digit)
                        acc <= acc * 32'd10 + digit;
                end else if (state == S_STR) begin
                    idx <= idx + 32'd1;
                end
`ifdef SYSCALL_READ_CHAR_EN
                else if (state == S_CHR) begin
                    acc <= {24'd0, in_data};
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_syscall_input.sv
// tb_syscall_input: table vectors, hand sequences and randomized
// read_int/read_string traffic checked against a behavioural model.
module tb_syscall_input;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall_control;
    logic [31:0] v0;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        sysstall;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    syscall_input dut (
        .clk(clk), .reset(reset),
        .syscall_control(syscall_control),
        .v0(v0), .a0(a0), .a1(a1),
        .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sysstall(sysstall),
        .rd_we(rd_we), .rd_data(rd_data),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [31:0] base;
        logic [31:0] size;
        string       bytes;
        bit          stall;
        bit          has_rd;
        logic [31:0] rd;
        string       wr;
        bit          term;
        int          used;
    } vec_t;

    vec_t        tbl[$];
    int          n_chk = 0;
    int          n_fail = 0;

    byte unsigned stim[$];
    logic [31:0] w_addr[$];
    logic [7:0]  w_data[$];
    logic [31:0] rd_vals[$];
    logic [31:0] exp_a[$];
    logic [7:0]  exp_d[$];
    int          used;
    bit          entry_stall;
    bit          timed_out;
    bit          drop_ok;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void add(logic [31:0] code, logic [31:0] base,
                                logic [31:0] size, string bytes,
                                bit stall, bit has_rd, logic [31:0] rd,
                                string wr, bit term, int used_n);
        vec_t v;
        v.code = code; v.base = base; v.size = size; v.bytes = bytes;
        v.stall = stall; v.has_rd = has_rd; v.rd = rd;
        v.wr = wr; v.term = term; v.used = used_n;
        tbl.push_back(v);
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; syscall_control = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one syscall: entry cycle, then one sample per cycle until
    // sysstall drops. noise raises syscall_control while busy.
    task automatic run_op(input logic [31:0] code, input logic [31:0] av0,
                          input logic [31:0] av1, input bit gaps,
                          input bit noise);
        int last_evt;
        bit nl_seen;
        w_addr.delete(); w_data.delete(); rd_vals.delete();
        used = 0; timed_out = 1'b1; drop_ok = 1'b0;
        last_evt = -1; nl_seen = 1'b0;
        @(negedge clk);
        syscall_control = 1'b1; v0 = code; a0 = av0; a1 = av1;
        in_valid = 1'b0; in_data = 8'($urandom);
        #1 entry_stall = sysstall;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            syscall_control = noise && !nl_seen;
            v0 = 32'd8; a0 = $urandom; a1 = $urandom;
            if (stim.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1; in_data = stim[0];
            end else begin
                in_valid = 1'b0; in_data = 8'($urandom);
            end
            #1;
            check("excl", 32'(mem_we & rd_we), 32'd0);
            if (mem_we) begin
                w_addr.push_back(mem_addr);
                w_data.push_back(mem_wdata);
                last_evt = cyc;
            end
            if (rd_we) begin
                rd_vals.push_back(rd_data);
                last_evt = cyc;
            end
            if (in_valid && in_ready) begin
                if (stim[0] == 8'h0A) nl_seen = 1'b1;
                void'(stim.pop_front());
                used++;
            end
            if (!sysstall) begin
                timed_out = 1'b0;
                drop_ok = (last_evt < 0) || (last_evt == cyc - 1);
                break;
            end
        end
        in_valid = 1'b0; syscall_control = 1'b0;
        stim.delete();
        if (timed_out) begin
            check("op_timeout", 32'd1, 32'd0);
            pulse_reset();
        end
    endtask

    function automatic void compare(string tag, bit e_stall, bit e_rd,
                                    logic [31:0] e_rdv, int e_used);
        check({tag, " stall"}, 32'(entry_stall), 32'(e_stall));
        check({tag, " rd_cnt"}, 32'(rd_vals.size()), 32'(e_rd));
        if (e_rd && rd_vals.size() > 0)
            check({tag, " rd"}, rd_vals[0], e_rdv);
        check({tag, " wcnt"}, 32'(w_addr.size()), 32'(exp_a.size()));
        for (int k = 0; k < w_addr.size() && k < exp_a.size(); k++) begin
            check($sformatf("%s waddr%0d", tag, k), w_addr[k], exp_a[k]);
            check($sformatf("%s wdata%0d", tag, k),
                  32'(w_data[k]), 32'(exp_d[k]));
        end
        check({tag, " used"}, 32'(used), 32'(e_used));
        check({tag, " drop"}, 32'(drop_ok), 32'd1);
    endfunction

    task automatic check_zero(string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " sysstall"}, 32'(sysstall), 32'd0);
        check({tag, " rd_we"}, 32'(rd_we), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check({tag, " rd_data"}, rd_data, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        vec_t        v;
        byte unsigned q[$];
        logic [31:0] acc;
        logic [31:0] base;
        int          n;
        int          k;
        int          e_used;
        bit          neg;
        bit          is_int;

        reset = 1'b1; syscall_control = 1'b1; v0 = 32'd5;
        a0 = 32'd0; a1 = 32'd0; in_valid = 1'b1; in_data = 8'h31;
        #1 check_zero("reset");
        @(negedge clk);
        check_zero("reset2");
        syscall_control = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        add(5, 0, 0, "123\n", 1, 1, 32'd123, "", 0, 4);
        add(5, 0, 0, "-4x5\n", 1, 1, 32'hFFFF_FFD3, "", 0, 5);
        add(5, 0, 0, "\n", 1, 1, 32'd0, "", 0, 1);
        add(5, 0, 0, "12-3\n", 1, 1, 32'd123, "", 0, 5);
        add(5, 0, 0, "4294967297\n", 1, 1, 32'd1, "", 0, 11);
        add(5, 0, 0, "-\n", 1, 1, 32'd0, "", 0, 2);
        add(8, 32'h100, 4, "abcdef", 1, 0, 0, "abc", 1, 3);
        add(8, 32'h200, 8, "hi\nzz", 1, 0, 0, "hi\n", 1, 3);
        add(8, 32'h300, 0, "xyz", 1, 0, 0, "", 0, 0);
        add(8, 32'h400, 1, "q", 1, 0, 0, "", 1, 0);
        add(8, 32'hFFFF_FFFE, 5, "wxyz!", 1, 0, 0, "wxyz", 1, 4);
        add(8, 32'h500, 32'hFFFF_FFFF, "ok\nmore", 1, 0, 0, "ok\n", 1, 3);
        add(3, 0, 0, "9\n", 0, 0, 0, "", 0, 0);
        add(32'h105, 0, 0, "9\n", 0, 0, 0, "", 0, 0);
`ifdef SYSCALL_READ_CHAR_EN
        add(12, 0, 0, "AB", 1, 1, 32'h41, "", 0, 1);
`else
        add(12, 0, 0, "AB", 0, 0, 0, "", 0, 0);
`endif

        for (int t = 0; t < tbl.size(); t++) begin
            v = tbl[t];
            stim.delete();
            for (int j = 0; j < v.bytes.len(); j++)
                stim.push_back(v.bytes[j]);
            exp_a.delete(); exp_d.delete();
            for (int j = 0; j < v.wr.len(); j++) begin
                exp_a.push_back(v.base + 32'(j));
                exp_d.push_back(v.wr[j]);
            end
            if (v.term) begin
                exp_a.push_back(v.base + 32'(v.wr.len()));
                exp_d.push_back(8'h00);
            end
            run_op(v.code, v.base, v.size, (t % 2) == 1, 1'b0);
            compare($sformatf("vec%0d", t), v.stall, v.has_rd, v.rd, v.used);
        end

        // Reset in the middle of read_int after "12".
        @(negedge clk);
        syscall_control = 1'b1; v0 = 32'd5;
        @(negedge clk);
        syscall_control = 1'b0; in_valid = 1'b1; in_data = "1";
        @(negedge clk);
        in_data = "2";
        @(negedge clk);
        reset = 1'b1; in_data = 8'h0A;
        syscall_control = 1'b1;
        #1 check_zero("midrst");
        @(negedge clk);
        check_zero("midrst2");
        syscall_control = 1'b0; in_valid = 1'b0;
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            #1;
            check("post_rst rd_we", 32'(rd_we), 32'd0);
            check("post_rst stall", 32'(sysstall), 32'd0);
        end
        stim = '{8'h37, 8'h0A};
        exp_a.delete(); exp_d.delete();
        run_op(5, 0, 0, 1'b0, 1'b0);
        compare("after_rst", 1'b1, 1'b1, 32'd7, 2);

        // Randomized traffic against the behavioural model.
        for (int r = 0; r < 60; r++) begin
            q.delete();
            exp_a.delete(); exp_d.delete();
            is_int = $urandom_range(0, 1) == 1;
            acc = 32'd0;
            neg = 1'b0;
            e_used = 0;
            if (is_int) begin
                if ($urandom_range(0, 2) == 0) q.push_back(8'h2D);
                n = $urandom_range(0, 12);
                for (int j = 0; j < n; j++) begin
                    case ($urandom_range(0, 5))
                        0: q.push_back(8'(8'h41 + $urandom_range(0, 25)));
                        1: q.push_back(8'h2D);
                        default: q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                    endcase
                end
                q.push_back(8'h0A);
                n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) q.push_back(8'h35);
                foreach (q[j]) begin
                    e_used++;
                    if (q[j] == 8'h0A) break;
                    if (j == 0 && q[j] == 8'h2D)
                        neg = 1'b1;
                    else if (q[j] >= 8'h30 && q[j] <= 8'h39)
                        acc = acc * 32'd10 + 32'(q[j] - 8'h30);
                end
                if (neg) acc = 32'd0 - acc;
                stim = q;
                run_op(5, $urandom, $urandom, 1'b1,
                       $urandom_range(0, 1) == 1);
                compare($sformatf("rint%0d", r), 1'b1, 1'b1, acc, e_used);
            end else begin
                base = $urandom;
                n = $urandom_range(0, 9);
                for (int j = 0; j < n + 2; j++) begin
                    if ($urandom_range(0, 4) == 0)
                        q.push_back(8'h0A);
                    else
                        q.push_back(8'($urandom));
                end
                k = 0;
                if (n != 0) begin
                    while (k < n - 1) begin
                        exp_a.push_back(base + 32'(k));
                        exp_d.push_back(q[k]);
                        k++;
                        if (q[k - 1] == 8'h0A) break;
                    end
                    exp_a.push_back(base + 32'(k));
                    exp_d.push_back(8'h00);
                end
                stim = q;
                run_op(8, base, 32'(n), 1'b1, 1'b0);
                compare($sformatf("rstr%0d", r), 1'b1, 1'b0, 32'd0, k);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
